simd256_host: RTL and testbench

SIMD256_HOST -- requirements
Module: simd256_host

---
 rtl/simd256_pkg.sv | 24 ++
 rtl/simd256_wdog.sv | 38 +++
 rtl/simd256.sv | 154 +++++++++++++++
 tb/tb_simd256_host.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd256_pkg.sv
// +----------------------------------------------------------------------+
// | simd256_pkg : shared width, timeout default and host FSM encoding    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package simd256_pkg;

  localparam int c_DATA_W          = 512;
  localparam int c_TIMEOUT_CYC_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_WAIT_INIT = 3'd2,
    ST_FETCH     = 3'd3,
    ST_ENA       = 3'd4,
    ST_WAIT_FIN  = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/simd256_wdog.sv
// +----------------------------------------------------------------------+
// | simd256_wdog : counts cycles spent waiting on the round core and     |
// |                flags expiry after TIMEOUT_CYC cycles without kick    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module simd256_wdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int                c_CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_CW-1:0]   c_LAST = c_CW'(TIMEOUT_CYC - 1);

  logic [c_CW-1:0] r_cnt;

  // Restarts from zero every time the host enters a wait state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run) begin
      r_cnt <= '0;
    end else if (r_cnt != c_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = run && !kick && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/simd256.sv
// +----------------------------------------------------------------------+
// | simd256_host : sequences iv load and message blocks through the      |
// |                round core; optional watchdog via SIMD256_TIMEOUT_EN  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module simd256_host
  import simd256_pkg::*;
#(
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [c_DATA_W-1:0] iv_i,
  input  logic                blk_valid,
  output logic                blk_ready,
  input  logic [c_DATA_W-1:0] blk_data,
  input  logic                blk_last,
  output logic                core_init,
  output logic                core_ena,
  output logic                core_mode,
  output logic [c_DATA_W-1:0] core_data,
  output logic [c_DATA_W-1:0] core_stat,
  input  logic [c_DATA_W-1:0] core_stat_o,
  input  logic                core_fin,
  output logic [c_DATA_W-1:0] digest,
  output logic                digest_valid,
  output logic                busy,
  output logic                err
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [c_DATA_W-1:0] r_chain;
  logic [c_DATA_W-1:0] r_blk;
  logic                r_last;
  logic [c_DATA_W-1:0] r_digest;
  logic                w_timeout;
  logic                w_waiting;
  logic                w_start_acc;
  logic                w_blk_acc;

  assign w_waiting   = (r_state == ST_WAIT_INIT) || (r_state == ST_WAIT_FIN);
  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_blk_acc   = (r_state == ST_FETCH) && blk_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    blk_ready    = 1'b0;
    core_init    = 1'b0;
    core_ena     = 1'b0;
    digest_valid = 1'b0;
    busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE:      if (start) w_state_nxt = ST_INIT;
      ST_INIT: begin
        core_init   = 1'b1;
        w_state_nxt = ST_WAIT_INIT;
      end
      ST_WAIT_INIT: begin
        if (core_fin)       w_state_nxt = ST_FETCH;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_FETCH: begin
        blk_ready = 1'b1;
        if (blk_valid) w_state_nxt = ST_ENA;
      end
      ST_ENA: begin
        core_ena    = 1'b1;
        w_state_nxt = ST_WAIT_FIN;
      end
      ST_WAIT_FIN: begin
        if (core_fin)       w_state_nxt = r_last ? ST_DONE : ST_FETCH;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_DONE: begin
        digest_valid = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Digest is captured alongside the final chain update so it is already
  // valid during the DONE cycle that qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain  <= '0;
      r_blk    <= '0;
      r_last   <= 1'b0;
      r_digest <= '0;
    end else begin
      if (w_start_acc) r_chain <= iv_i;
      if (w_blk_acc) begin
        r_blk  <= blk_data;
        r_last <= blk_last;
      end
      if ((r_state == ST_WAIT_FIN) && core_fin) begin
        r_chain <= core_stat_o;
        if (r_last) r_digest <= core_stat_o;
      end
    end
  end

  assign core_stat = r_chain;
  assign core_data = r_blk;
  assign core_mode = r_last;
  assign digest    = r_digest;

`ifdef SIMD256_TIMEOUT_EN
  logic r_err;

  simd256_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (w_waiting),
    .kick    (core_fin),
    .expired (w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused;

  assign w_unused  = w_waiting;
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_simd256_host.sv
// Testbench for simd256_host: scoreboarded digests plus per-scenario checks.
`timescale 1ns/1ps

module tb_simd256_host;
  import simd256_pkg::*;

  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [511:0] iv_i = '0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_last = 1'b0;
  logic         core_init, core_ena, core_mode;
  logic [511:0] core_data, core_stat;
  logic [511:0] core_stat_o = '0;
  logic         core_fin = 1'b0;
  logic [511:0] digest;
  logic         digest_valid, busy, err;

  int checks = 0;
  int errors = 0;
  int init_cnt = 0, ena_cnt = 0, dv_cnt = 0;
  logic [511:0] exp_q[$];

  simd256_host #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .iv_i(iv_i),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_last(blk_last), .core_init(core_init), .core_ena(core_ena),
    .core_mode(core_mode), .core_data(core_data), .core_stat(core_stat),
    .core_stat_o(core_stat_o), .core_fin(core_fin), .digest(digest),
    .digest_valid(digest_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Digest scoreboard and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (core_init) init_cnt++;
    if (core_ena) ena_cnt++;
    if (digest_valid) begin
      dv_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_digest: unexpected digest_valid, digest=%h", digest);
      end else begin
        logic [511:0] e;
        e = exp_q.pop_front();
        if (digest !== e) begin
          errors++;
          $display("FAIL sb_digest: got %h want %h", digest, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [511:0] iv);
    iv_i  = iv;
    start = 1'b1;
    tick();
    start = 1'b0;
    iv_i  = rnd512();
  endtask

  task automatic core_done(input logic [511:0] r);
    core_stat_o = r;
    core_fin    = 1'b1;
    tick();
    core_fin    = 1'b0;
    core_stat_o = rnd512();
  endtask

  task automatic give_block(input logic [511:0] d, input logic l);
    blk_data  = d;
    blk_last  = l;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    blk_data  = rnd512();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, blk_ready, core_init, core_ena, core_mode, digest_valid, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {busy, blk_ready, core_init, core_ena, core_mode, digest_valid, err});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (core_data !== '0 || core_stat !== '0 || digest !== '0) begin
      errors++;
      $display("FAIL reset_data: data=%h stat=%h dig=%h want 0", core_data, core_stat, digest);
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b err=%b want 0 0", busy, err);
    end
  endtask

  task automatic test_single();
    logic [511:0] iv, d, r;
    int i0, e0, d0;
    bit bad;
    iv = {128{4'h5}};
    i0 = init_cnt; e0 = ena_cnt; d0 = dv_cnt;
    pulse_start(iv);
    checks++;
    if (core_init !== 1'b1 || core_stat !== iv) begin
      errors++;
      $display("FAIL single_init: core_init=%b stat=%h want 1 %h", core_init, core_stat, iv);
    end
    tick();
    checks++;
    if (core_init !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_wait_init: core_init=%b busy=%b want 0 1", core_init, busy);
    end
    core_done(rnd512());
    checks++;
    if (blk_ready !== 1'b1 || core_stat !== iv) begin
      errors++;
      $display("FAIL single_fetch: ready=%b stat=%h want 1 %h", blk_ready, core_stat, iv);
    end
    d = rnd512();
    give_block(d, 1'b1);
    checks++;
    if (core_ena !== 1'b1 || core_data !== d || core_mode !== 1'b1 || blk_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ena: ena=%b mode=%b ready=%b want 1 1 0", core_ena, core_mode, blk_ready);
    end
    tick();
    bad = 0;
    for (int k = 0; k < 43; k++) begin
      if (core_data !== d || core_ena !== 1'b0 || busy !== 1'b1) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL single_hold: got unstable data/ena during wait want stable");
    end
    r = rnd512();
    exp_q.push_back(r);
    core_done(r);
    checks++;
    if (core_stat !== r || digest_valid !== 1'b1 || digest !== r) begin
      errors++;
      $display("FAIL single_done: dv=%b stat=%h want 1 %h", digest_valid, core_stat, r);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || digest_valid !== 1'b0 || digest !== r) begin
      errors++;
      $display("FAIL single_idle: busy=%b dv=%b digest=%h want 0 0 %h", busy, digest_valid, digest, r);
    end
    checks++;
    if (dv_cnt - d0 != 1 || init_cnt - i0 != 1 || ena_cnt - e0 != 1) begin
      errors++;
      $display("FAIL single_pulses: dv=%0d init=%0d ena=%0d want 1 1 1",
               dv_cnt - d0, init_cnt - i0, ena_cnt - e0);
    end
  endtask

  task automatic test_multi();
    logic [511:0] d, r;
    int e0;
    bit bad;
    e0 = ena_cnt;
    pulse_start(rnd512());
    tick();
    core_done(rnd512());
    for (int b = 0; b < 3; b++) begin
      bad = 0;
      for (int k = 0; k < 5; k++) begin
        if (blk_ready !== 1'b1 || core_ena !== 1'b0) bad = 1;
        tick();
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL multi_gap%0d: got ready/ena wrong during gap want ready=1 ena=0", b);
      end
      d = rnd512();
      give_block(d, b == 2);
      checks++;
      if (core_ena !== 1'b1 || core_mode !== (b == 2)) begin
        errors++;
        $display("FAIL multi_ena%0d: ena=%b mode=%b want 1 %b", b, core_ena, core_mode, b == 2);
      end
      tick();
      bad = 0;
      for (int k = 0; k < 6; k++) begin
        if (core_data !== d || core_mode !== (b == 2)) bad = 1;
        tick();
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL multi_hold%0d: got unstable core_data/core_mode want stable", b);
      end
      r = rnd512();
      if (b == 2) exp_q.push_back(r);
      core_done(r);
      checks++;
      if (core_stat !== r || blk_ready !== (b != 2)) begin
        errors++;
        $display("FAIL multi_chain%0d: ready=%b stat=%h want %b %h", b, blk_ready, core_stat, b != 2, r);
      end
    end
    tick();
    checks++;
    if (ena_cnt - e0 != 3) begin
      errors++;
      $display("FAIL multi_ena_count: got %0d want 3", ena_cnt - e0);
    end
  endtask

  task automatic test_start_ignored();
    logic [511:0] iv1, r;
    int i0;
    i0 = init_cnt;
    iv1 = rnd512();
    pulse_start(iv1);
    tick();
    core_done(rnd512());
    give_block(rnd512(), 1'b1);
    tick();
    pulse_start(rnd512());
    checks++;
    if (core_init !== 1'b0 || core_stat !== iv1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_ign: init=%b busy=%b stat=%h want 0 1 %h", core_init, busy, core_stat, iv1);
    end
    tick(); tick();
    r = rnd512();
    exp_q.push_back(r);
    core_done(r);
    tick();
    checks++;
    if (init_cnt - i0 != 1) begin
      errors++;
      $display("FAIL start_ign_init_count: got %0d want 1", init_cnt - i0);
    end
  endtask

  task automatic test_spurious_fin();
    logic [511:0] iv, r;
    iv = rnd512();
    pulse_start(iv);
    tick();
    core_done(rnd512());
    core_done(rnd512());
    checks++;
    if (core_stat !== iv || blk_ready !== 1'b1) begin
      errors++;
      $display("FAIL spurious_fin: ready=%b stat=%h want 1 %h", blk_ready, core_stat, iv);
    end
    give_block(rnd512(), 1'b1);
    tick();
    r = rnd512();
    exp_q.push_back(r);
    core_done(r);
    tick();
  endtask

  task automatic test_reset_mid();
    pulse_start(rnd512());
    tick();
    core_done(rnd512());
    give_block(rnd512(), 1'b0);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, blk_ready, core_init, core_ena, core_mode, digest_valid, err} !== 7'b0 ||
        core_data !== '0 || core_stat !== '0 || digest !== '0) begin
      errors++;
      $display("FAIL reset_mid: ctrl=%b data0=%b stat0=%b dig0=%b want all zero",
               {busy, blk_ready, core_init, core_ena, core_mode, digest_valid, err},
               core_data == '0, core_stat == '0, digest == '0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%b want 0", busy);
    end
  endtask

`ifdef SIMD256_TIMEOUT_EN
  task automatic test_timeout();
    logic [511:0] r;
    int d0;
    bit bad;
    d0 = dv_cnt;
    pulse_start(rnd512());
    tick();
    bad = 0;
    for (int k = 0; k < TO - 1; k++) begin
      if (busy !== 1'b1 || err !== 1'b0) bad = 1;
      tick();
    end
    checks++;
    if (bad || busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: busy=%b err=%b want 1 0 through cycle %0d", busy, err, TO);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || dv_cnt != d0) begin
      errors++;
      $display("FAIL timeout_fire: busy=%b err=%b dv=%0d want 0 1 0", busy, err, dv_cnt - d0);
    end
    pulse_start(rnd512());
    checks++;
    if (err !== 1'b0 || core_init !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: err=%b init=%b want 0 1", err, core_init);
    end
    tick();
    core_done(rnd512());
    give_block(rnd512(), 1'b1);
    tick();
    r = rnd512();
    exp_q.push_back(r);
    core_done(r);
    tick();
  endtask
`endif

  initial begin
    core_stat_o = rnd512();
    test_reset();
    test_single();
    test_multi();
    test_start_ignored();
    test_spurious_fin();
`ifdef SIMD256_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending digests want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
